// File: rtl/serial_loader_if.sv
// Serial load bus: one-bit data in with a start request, parallel word out with a load strobe.
// The bench drives the master side; serial_loader sits on the slave side.
interface serial_loader_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             serial_in;
  logic [WIDTH-1:0] value_out;
  logic             load_out;
  logic             busy;

  modport master (
    output start,
    output serial_in,
    input  value_out,
    input  load_out,
    input  busy
  );

  modport slave (
    input  start,
    input  serial_in,
    output value_out,
    output load_out,
    output busy
  );
endinterface

// File: rtl/serial_loader.sv
// Bit-serial (MSB first) word assembler feeding a parallel Register; load_out pulses WIDTH
// cycles after start is sampled. There is no backpressure: the downstream must take the strobe.
module serial_loader #(
  parameter int WIDTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  serial_loader_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] shift_next;

  assign shift_next = {shift[WIDTH-2:0], bus.serial_in};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      shift   <= '0;
      value_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= SHIFT;
            count <= '0;
          end
        end
        SHIFT: begin
          shift <= shift_next;
          // The word is published on the same edge that captures the LSB.
          if (count == LAST) begin
            state   <= LOAD;
            value_q <= shift_next;
            count   <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        LOAD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode only registered state, so reset removes the strobe without waiting for a clock.
  assign bus.value_out = value_q;
  assign bus.load_out  = (state == LOAD);
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: stimulus pushes expected strobes into a queue that an
// independent monitor drains on every load_out cycle.
module tb_serial_loader;
  logic clock;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] last_word = 16'h0000;
  logic [15:0] reg_out;

  typedef struct {
    logic [15:0] word;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  serial_loader_if #(.WIDTH(16)) bus ();

  serial_loader #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Downstream Register model.
  always @(posedge clock or posedge reset) begin
    if (reset) reg_out <= 16'h0000;
    else if (bus.load_out) reg_out <= bus.value_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.load_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe got value 0x%0h want no strobe (cycle %0d)", bus.value_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_value", bus.value_out, e.word);
          check("strobe_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at the following IDLE negedge.
  task automatic send(input logic [15:0] w, input bit hold, input bit poke, input bit rst_load,
                      output int e0);
    exp_t e;
    bus.start = 1'b1;
    @(negedge clock);
    e0 = cyc;
    check("busy_accept", bus.busy, 1);
    check("value_hold_start", bus.value_out, last_word);
    e.word = w;
    e.cyc  = cyc + 16;
    exp_q.push_back(e);
    if (!hold) bus.start = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      bus.serial_in = w[i];
      if (poke) bus.start = (i == 10);
      if (i == 7) check("value_hold_mid", bus.value_out, last_word);
      @(negedge clock);
    end
    last_word = w;
    check("busy_load", bus.busy, 1);
    if (poke) bus.start = 1'b1;
    if (rst_load) begin
      #2 reset = 1'b1;
      #1;
      check("rst_load_load", bus.load_out, 0);
      check("rst_load_value", bus.value_out, 0);
      check("rst_load_busy", bus.busy, 0);
      last_word = 16'h0000;
      @(negedge clock);
      reset = 1'b0;
    end else begin
      @(negedge clock);
      check("busy_idle", bus.busy, 0);
      check("load_idle", bus.load_out, 0);
      if (!hold) bus.start = 1'b0;
    end
  endtask

  initial begin
    int e0a, e0b, e0c;
    logic [15:0] w;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.serial_in = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_value", bus.value_out, 0);
    check("reset_load", bus.load_out, 0);
    check("reset_busy", bus.busy, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_busy", bus.busy, 0);

    send(16'h001F, 0, 0, 0, e0a);
    check("reg_out_31", reg_out, 31);

    send(16'h007F, 0, 0, 0, e0a);
    send(16'h8001, 0, 0, 0, e0b);
    check("back_to_back_period", e0b - e0a, 18);
    check("reg_out_8001", reg_out, 16'h8001);

    // Abort after 8 bits of 0xABCD, then release reset with start already high.
    w = 16'hABCD;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 15; i >= 8; i--) begin
      bus.serial_in = w[i];
      @(negedge clock);
    end
    check("abort_busy_before", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_load", bus.load_out, 0);
    check("abort_value", bus.value_out, 0);
    last_word = 16'h0000;
    bus.start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    send(16'h1234, 0, 0, 0, e0a);

    // Start held high throughout.
    send(16'h03FF, 1, 0, 0, e0a);
    send(16'h03FF, 1, 0, 0, e0b);
    send(16'h03FF, 1, 0, 0, e0c);
    bus.start = 1'b0;
    check("hold_period_1", e0b - e0a, 18);
    check("hold_period_2", e0c - e0b, 18);

    // Start pulsed in SHIFT and in LOAD must not restart.
    send(16'hFFFF, 0, 1, 0, e0a);
    @(negedge clock);
    check("no_restart_busy", bus.busy, 0);

    send(16'h0000, 0, 0, 0, e0a);
    send(16'h5A5A, 0, 0, 1, e0a);

    repeat (20) @(negedge clock);
    check("no_pending_strobes", exp_q.size(), 0);
    check("final_value", bus.value_out, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
